// File: rtl/tlc_frame_loader_if.sv
// rtl/tlc_frame_loader_if.sv - write/control/frame bus of tlc_frame_loader
//
// Groups every non-clock, non-reset signal of the frame loader.
//   master : writer side (drives wr_*, clear_req, commit_req, optional bright)
//   slave  : tlc_frame_loader side (drives wr_ready, busy, commit_done,
//            frame_count, data_register0..3)
// Optional feature macro: TLC_FRAME_LOADER_SCALE_EN adds bright[7:0].
interface tlc_frame_loader_if;
  logic         wr_valid;
  logic         wr_ready;
  logic [1:0]   wr_chip;
  logic [3:0]   wr_chan;
  logic [11:0]  wr_value;
  logic         clear_req;
  logic         commit_req;
  logic         busy;
  logic         commit_done;
  logic [15:0]  frame_count;
  logic [193:2] data_register0;
  logic [193:2] data_register1;
  logic [193:2] data_register2;
  logic [193:2] data_register3;
`ifdef TLC_FRAME_LOADER_SCALE_EN
  logic [7:0]   bright;
`endif

  modport master (
`ifdef TLC_FRAME_LOADER_SCALE_EN
    output bright,
`endif
    output wr_valid, wr_chip, wr_chan, wr_value, clear_req, commit_req,
    input  wr_ready, busy, commit_done, frame_count,
    input  data_register0, data_register1, data_register2, data_register3
  );

  modport slave (
`ifdef TLC_FRAME_LOADER_SCALE_EN
    input  bright,
`endif
    input  wr_valid, wr_chip, wr_chan, wr_value, clear_req, commit_req,
    output wr_ready, busy, commit_done, frame_count,
    output data_register0, data_register1, data_register2, data_register3
  );
endinterface

// File: rtl/tlc_frame_loader.sv
// rtl/tlc_frame_loader.sv - double-buffered grayscale frame loader for four TLC5940 chains
//
// Ports:
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : tlc_frame_loader_if.slave
//          wr_valid/wr_ready/wr_chip/wr_chan/wr_value : channel write
//          clear_req  : fill back buffer with CLEAR_VALUE (64 cycles)
//          commit_req : copy back buffer to front buffer
//          busy, commit_done, frame_count            : status
//          data_register0..3                          : front buffer per chain
// Optional feature macro: TLC_FRAME_LOADER_SCALE_EN (brightness scaling,
// adds bus.bright and one write pipeline stage).
module tlc_frame_loader #(
  parameter logic [11:0] CLEAR_VALUE = 12'h000
) (
  input logic               clk,
  input logic               rst,
  tlc_frame_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, COMMIT = 2'd2} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_commit_pend;
  logic                   w_commit_pend_nxt;
  logic [5:0]             r_clr_idx;
  logic [3:0][15:0][11:0] r_back;
  logic [3:0][15:0][11:0] r_front;
  logic                   r_commit_done;
  logic [15:0]            r_frame_count;

  logic                   w_wr_fire;
  logic                   w_pipe_busy;
  logic                   w_back_we;
  logic [1:0]             w_back_chip;
  logic [3:0]             w_back_chan;
  logic [11:0]            w_back_value;

  assign w_wr_fire = bus.wr_valid && bus.wr_ready;

`ifdef TLC_FRAME_LOADER_SCALE_EN
  // Scaling stage: value * (bright + 1) / 256, so bright = 255 is unity gain.
  logic [20:0] w_prod;
  logic        r_wp_valid;
  logic [1:0]  r_wp_chip;
  logic [3:0]  r_wp_chan;
  logic [11:0] r_wp_value;

  assign w_prod = {9'd0, bus.wr_value} * {12'd0, ({1'b0, bus.bright} + 9'd1)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp_valid <= 1'b0;
      r_wp_chip  <= 2'd0;
      r_wp_chan  <= 4'd0;
      r_wp_value <= 12'd0;
    end else begin
      r_wp_valid <= w_wr_fire;
      r_wp_chip  <= bus.wr_chip;
      r_wp_chan  <= bus.wr_chan;
      r_wp_value <= w_prod[19:8];
    end
  end

  assign w_pipe_busy  = r_wp_valid;
  assign w_back_we    = r_wp_valid;
  assign w_back_chip  = r_wp_chip;
  assign w_back_chan  = r_wp_chan;
  assign w_back_value = r_wp_value;
`else
  assign w_pipe_busy  = 1'b0;
  assign w_back_we    = w_wr_fire;
  assign w_back_chip  = bus.wr_chip;
  assign w_back_chan  = bus.wr_chan;
  assign w_back_value = bus.wr_value;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_commit_pend <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_commit_pend <= w_commit_pend_nxt;
    end
  end

  // A commit that cannot run yet (write still in flight, or clear in
  // progress) is remembered and runs as soon as the blocker is gone.
  always_comb begin
    w_state_nxt       = r_state;
    w_commit_pend_nxt = r_commit_pend;
    case (r_state)
      IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt       = CLEAR;
          w_commit_pend_nxt = r_commit_pend || bus.commit_req;
        end else if ((bus.commit_req || r_commit_pend) && !w_pipe_busy) begin
          w_state_nxt       = COMMIT;
          w_commit_pend_nxt = 1'b0;
        end else if (bus.commit_req) begin
          w_commit_pend_nxt = 1'b1;
        end
      end
      CLEAR: begin
        if (bus.commit_req) begin
          w_commit_pend_nxt = 1'b1;
        end
        if (r_clr_idx == 6'd63) begin
          if (r_commit_pend || bus.commit_req) begin
            w_state_nxt       = COMMIT;
            w_commit_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Clear writes come after the pipeline write in this block so that a
  // clear always wins over an older write landing on the same channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_back        <= {64{CLEAR_VALUE}};
      r_front       <= {64{CLEAR_VALUE}};
      r_clr_idx     <= 6'd0;
      r_commit_done <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_commit_done <= 1'b0;
      if (w_back_we) begin
        r_back[w_back_chip][w_back_chan] <= w_back_value;
      end
      if (r_state == CLEAR) begin
        r_back[r_clr_idx[5:4]][r_clr_idx[3:0]] <= CLEAR_VALUE;
        r_clr_idx <= r_clr_idx + 6'd1;
      end else begin
        r_clr_idx <= 6'd0;
      end
      if (r_state == COMMIT) begin
        r_front       <= r_back;
        r_commit_done <= 1'b1;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.wr_ready = (r_state == IDLE) && !bus.clear_req && !bus.commit_req && !r_commit_pend;
  assign bus.busy           = (r_state != IDLE) || w_pipe_busy;
  assign bus.commit_done    = r_commit_done;
  assign bus.frame_count    = r_frame_count;
  assign bus.data_register0 = r_front[0];
  assign bus.data_register1 = r_front[1];
  assign bus.data_register2 = r_front[2];
  assign bus.data_register3 = r_front[3];

endmodule

// File: doc/tlc_frame_loader.md
TLC_FRAME_LOADER -- requirements
Module: tlc_frame_loader

Interface
REQ-001 SHALL have parameter CLEAR_VALUE, default 12'h000, meaning the grayscale value written to every channel by reset and by the clear operation.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port wr_valid, input, 1, the channel-write request.
REQ-005 SHALL have port wr_ready, output, 1, the write accept; a write transfers on a cycle with wr_valid && wr_ready.
REQ-006 SHALL have port wr_chip, input, 2, the target TLC5940 chain index 0..3.
REQ-007 SHALL have port wr_chan, input, 4, the target channel 0..15.
REQ-008 SHALL have port wr_value, input, 12, the grayscale value.
REQ-009 SHALL have port clear_req, input, 1, a one-cycle request to load CLEAR_VALUE into all 64 back-buffer channels.
REQ-010 SHALL have port commit_req, input, 1, a one-cycle request to copy the back buffer to the front buffer.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE or a write is in the pipeline.
REQ-012 SHALL have port commit_done, output, 1, a one-cycle pulse in the cycle after the front buffer updates.
REQ-013 SHALL have port frame_count, output, 16, the number of completed commits, wrapping.
REQ-014 SHALL have ports data_register0..3, output, [193:2] each, the front-buffer image for each chain, consumed by the TLC5940 serializer.

Function
REQ-015 SHALL store chip c, channel n in data_register<c>[n*12+13 : n*12+2], MSB at the higher index, so that channel 15 occupies [193:182].
REQ-016 SHALL hold a 768-bit back buffer, written by writes and clears, and a 768-bit front buffer that drives data_register0..3 directly from flops.
REQ-017 SHALL implement FSM states IDLE, CLEAR, COMMIT.
REQ-018 SHALL drive wr_ready = 1 only in IDLE with no clear_req or commit_req pending in the same cycle.
REQ-019 SHALL apply an accepted write to the back buffer at the next edge (latency 1), or latency 2 under REQ-031.
REQ-020 SHALL handle clear_req in IDLE as follows: enter CLEAR and write CLEAR_VALUE to one channel per cycle, index 0..63 (chip = idx[5:4], chan = idx[3:0]), then return to IDLE after index 63; this takes 64 cycles.
REQ-021 SHALL handle commit_req in IDLE with an empty write pipeline as follows: enter COMMIT; at the next edge, front <= back; then return to IDLE with commit_done = 1 for one cycle and frame_count + 1.
REQ-022 SHALL, when commit_req arrives while a write is in the pipeline, latch it as pending and service it once the pipeline drains; the write is included in the commit.
REQ-023 SHALL, when clear_req and commit_req assert in the same IDLE cycle, service the clear first, then the commit automatically; the committed frame is all CLEAR_VALUE.
REQ-024 SHALL record commit_req received during CLEAR as pending and service it after CLEAR.
REQ-025 SHALL ignore clear_req received during CLEAR or COMMIT.
REQ-026 SHALL, when wr_valid && wr_ready, clear_req and commit_req all assert in one cycle, accept the write, then perform the clear, then the commit.
REQ-027 SHALL leave the front buffer unchanged except in COMMIT, so the serializer never sees partial frames.
REQ-028 SHALL wrap frame_count from 16'hFFFF to 16'h0000 with no flag.

Reset
REQ-029 SHALL, on rst high at a clk edge, set: state IDLE; both buffers to CLEAR_VALUE in all channels; busy 0; commit_done 0; frame_count 0; pending flags 0; write pipeline empty; wr_ready 1 in the first cycle after rst falls.
REQ-030 SHALL, when rst asserts mid-CLEAR or mid-COMMIT, abort the operation, apply the REQ-029 values, and neither pulse commit_done nor increment frame_count.

Configuration
REQ-031 SHALL, with macro TLC_FRAME_LOADER_SCALE_EN defined, add input bright[7:0] and one pipeline stage, storing (wr_value * (bright + 1)) >> 8 truncated to 12 bits; bright = 8'hFF stores wr_value unchanged, and the write latency becomes 2.
REQ-032 SHALL, without TLC_FRAME_LOADER_SCALE_EN, have no bright port and store wr_value verbatim with latency 1.

Verification
REQ-033 SHALL verify: reset, then sample outputs -> data_register0..3 all 0, frame_count 0, wr_ready 1.
REQ-034 SHALL verify: write chip 2, chan 15, value 12'hABC, then commit -> data_register2[193:182] = 12'hABC, all other bits 0, one commit_done pulse, frame_count 1.
REQ-035 SHALL verify: write chip 0, chan 0, value 12'h123 without commit -> data_register0[13:2] remains 0 until commit_req, then reads 12'h123.
REQ-036 SHALL verify: clear_req and commit_req in the same cycle after filling all channels with 12'hFFF -> busy for at least 65 cycles, then all outputs = CLEAR_VALUE and frame_count + 1.
REQ-037 SHALL verify: rst asserted at clear index 30 -> no commit_done, frame_count 0, outputs = CLEAR_VALUE.
REQ-038 SHALL verify, with TLC_FRAME_LOADER_SCALE_EN: bright 8'h7F, write 12'h800, then commit -> channel reads 12'h400.
